icache_miss_scheduler: RTL

//  Tracks and sequences instruction-cache line misses for all strands of a core.

---
 rtl/icache_miss_scheduler.sv | 115 +++++++++++
 1 files changed

// File: rtl/icache_miss_scheduler.sv
// Queues I-cache line misses (one entry per line, strands merged) and issues one L2 request at a time, oldest first.
// Latency: miss->request 1 cycle, response->complete pulse 1 cycle; a request is held stable until l2_req_ready.
module icache_miss_scheduler #(
    parameter int STRANDS      = 4,
    parameter int STRAND_IDX_W = 2,
    parameter int LINE_ADDR_W  = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    miss_valid,
    input  logic [STRAND_IDX_W-1:0] miss_strand,
    input  logic [LINE_ADDR_W-1:0]  miss_line,
    output logic                    l2_req_valid,
    output logic [LINE_ADDR_W-1:0]  l2_req_line,
    input  logic                    l2_req_ready,
    input  logic                    l2_resp_valid,
    output logic                    fill_valid,
    output logic [LINE_ADDR_W-1:0]  fill_line,
    output logic [STRANDS-1:0]      load_complete_strands,
    output logic                    load_collision
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic [STRANDS-1:0]       ent_valid;
    logic [LINE_ADDR_W-1:0]   ent_line [STRANDS];
    logic [STRANDS-1:0]       ent_mask [STRANDS];
    logic [STRAND_IDX_W-1:0]  head, tail;
    logic [STRAND_IDX_W:0]    count, count_nxt;
    logic [STRANDS-1:0]       complete_q;
    logic [STRANDS-1:0]       hit_vec;
    logic [STRANDS-1:0]       pending_strands;
    logic [STRANDS-1:0]       miss_onehot;
    logic                     merge, alloc, retire;

    function automatic logic [STRAND_IDX_W-1:0] ptr_inc(input logic [STRAND_IDX_W-1:0] p);
        return (p == STRAND_IDX_W'(STRANDS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign miss_onehot           = STRANDS'(1) << miss_strand;
    assign retire                = (state == S_DONE);
    assign l2_req_valid          = (state == S_ISSUE);
    assign l2_req_line           = ent_line[head];
    assign fill_valid            = (state == S_WAIT) && l2_resp_valid;
    assign fill_line             = ent_line[head];
    assign load_complete_strands = complete_q;
    assign load_collision        = miss_valid && fill_valid && (miss_line == ent_line[head]);

    // The head is excluded from merging while it retires: its mask has already been reported.
    always_comb begin
        hit_vec         = '0;
        pending_strands = '0;
        for (int i = 0; i < STRANDS; i++) begin
            pending_strands = pending_strands | ent_mask[i];
            if (ent_valid[i] && (ent_line[i] == miss_line) &&
                !(retire && (STRAND_IDX_W'(i) == head)))
                hit_vec[i] = 1'b1;
        end
        merge     = miss_valid && !load_collision && (hit_vec != '0);
        alloc     = miss_valid && !load_collision && (hit_vec == '0);
        count_nxt = count + {{STRAND_IDX_W{1'b0}}, alloc} - {{STRAND_IDX_W{1'b0}}, retire};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (count_nxt != '0) state_nxt = S_ISSUE;
            S_ISSUE: if (l2_req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (l2_resp_valid) state_nxt = S_DONE;
            S_DONE:  state_nxt = (count_nxt != '0) ? S_ISSUE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            complete_q <= '0;
            ent_valid  <= '0;
            for (int i = 0; i < STRANDS; i++) begin
                ent_line[i] <= '0;
                ent_mask[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            complete_q <= fill_valid ? ent_mask[head] : '0;
            if (retire) begin
                ent_valid[head] <= 1'b0;
                ent_mask[head]  <= '0;
                head            <= ptr_inc(head);
            end
            for (int i = 0; i < STRANDS; i++) begin
                if (merge && hit_vec[i])
                    ent_mask[i] <= ent_mask[i] | miss_onehot;
            end
            if (alloc) begin
                ent_valid[tail] <= 1'b1;
                ent_line[tail]  <= miss_line;
                ent_mask[tail]  <= miss_onehot;
                tail            <= ptr_inc(tail);
            end
        end
    end

    a_one_miss_per_strand: assert property (@(posedge clk) disable iff (reset)
        miss_valid |-> !pending_strands[miss_strand]);
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= (STRAND_IDX_W + 1)'(STRANDS));

endmodule
